// File: rtl/add_norm_pkg.sv
// Shared defaults and operand type for the post-add normalizer.
// The leading-zero count width is fixed at 6, enough for mantissas up to 64 bits.
package add_norm_pkg;

  localparam int DEF_MAN_WIDTH = 28;
  localparam int DEF_EXP_WIDTH = 10;
  localparam int DEF_CNT_WIDTH = 6;

  typedef struct packed {
    logic                     sign;
    logic [DEF_EXP_WIDTH-1:0] exp;
    logic [DEF_MAN_WIDTH-1:0] man;
  } norm_op_t;

endpackage : add_norm_pkg

// File: rtl/add_norm_if.sv
// Operand/result handshake bundle for add_norm; slave is the normalizer side,
// master is whoever drives operands and consumes results.
interface add_norm_if
  import add_norm_pkg::*;
#(
  parameter int MAN_WIDTH = DEF_MAN_WIDTH,
  parameter int EXP_WIDTH = DEF_EXP_WIDTH
);

  logic                 in_valid_i;
  logic                 in_ready_o;
  logic [MAN_WIDTH-1:0] man_i;
  logic [EXP_WIDTH-1:0] exp_i;
  logic                 sign_i;

  logic                 out_valid_o;
  logic                 out_ready_i;
  logic [MAN_WIDTH-1:0] man_o;
  logic [EXP_WIDTH-1:0] exp_o;
  logic                 sign_o;
  logic                 zero_o;
  logic                 denorm_o;

  modport slave (
    input  in_valid_i, man_i, exp_i, sign_i, out_ready_i,
    output in_ready_o, out_valid_o, man_o, exp_o, sign_o, zero_o, denorm_o
  );

  modport master (
    output in_valid_i, man_i, exp_i, sign_i, out_ready_i,
    input  in_ready_o, out_valid_o, man_o, exp_o, sign_o, zero_o, denorm_o
  );

endinterface : add_norm_if

// File: rtl/add_lzc.sv
// Combinational leading-zero (MODE=1) or trailing-zero (MODE=0) counter.
// cnt_o is 0 when the input is empty; empty_o flags that case.
module add_lzc #(
  parameter int WIDTH     = 28,
  parameter int MODE      = 1,
  parameter int CNT_WIDTH = 6
) (
  input  logic [WIDTH-1:0]     in_i,
  output logic [CNT_WIDTH-1:0] cnt_o,
  output logic                 empty_o
);

  logic found;

  always_comb begin
    cnt_o = '0;
    found = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      int idx;
      idx = (MODE != 0) ? (WIDTH - 1 - i) : i;
      if (!found && in_i[idx]) begin
        cnt_o = CNT_WIDTH'(i);
        found = 1'b1;
      end
    end
    empty_o = ~|in_i;
  end

endmodule : add_lzc

// File: rtl/add_norm.sv
// Two-stage normalizer for a raw adder sum: S1 captures the operand and counts
// leading zeros, S2 registers the barrel-shifted mantissa and adjusted exponent.
module add_norm
  import add_norm_pkg::*;
#(
  parameter int MAN_WIDTH = DEF_MAN_WIDTH,
  parameter int EXP_WIDTH = DEF_EXP_WIDTH,
  parameter int CNT_WIDTH = DEF_CNT_WIDTH
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       flush_i,
  add_norm_if.slave  bus
);

  localparam int CMP_W = (EXP_WIDTH + 1 > CNT_WIDTH) ? EXP_WIDTH + 1 : CNT_WIDTH;

  // Shift is capped at exp-1 so the result never drops below biased exponent 1;
  // compared one bit wider than the exponent so exp-1 cannot wrap.
  function automatic logic [CNT_WIDTH-1:0] shift_amt(
    input logic [EXP_WIDTH-1:0] e,
    input logic [CNT_WIDTH-1:0] lz
  );
    logic [CMP_W-1:0] em1;
    logic [CMP_W-1:0] lzx;
    em1 = CMP_W'(e) - CMP_W'(1);
    lzx = CMP_W'(lz);
    if (e == '0)
      return '0;
    else if (lzx <= em1)
      return lz;
    else
      return CNT_WIDTH'(em1);
  endfunction

  logic                 s1_adv;
  logic                 in_fire;
  logic                 s2_load;

  logic                 s1_valid_d, s1_valid_q;
  logic [MAN_WIDTH-1:0] s1_man_d,   s1_man_q;
  logic [EXP_WIDTH-1:0] s1_exp_d,   s1_exp_q;
  logic                 s1_sign_d,  s1_sign_q;

  logic [CNT_WIDTH-1:0] lzc_cnt;
  logic                 lzc_empty;
  logic [CNT_WIDTH-1:0] sh;
  logic [MAN_WIDTH-1:0] man_sh;
  logic [EXP_WIDTH-1:0] exp_sh;

  logic                 s2_valid_d,  s2_valid_q;
  logic [MAN_WIDTH-1:0] s2_man_d,    s2_man_q;
  logic [EXP_WIDTH-1:0] s2_exp_d,    s2_exp_q;
  logic                 s2_sign_d,   s2_sign_q;
  logic                 s2_zero_d,   s2_zero_q;
  logic                 s2_denorm_d, s2_denorm_q;

  assign s1_adv         = !s2_valid_q || bus.out_ready_i;
  assign bus.in_ready_o = (!s1_valid_q || s1_adv) && !flush_i;
  assign in_fire        = bus.in_valid_i && bus.in_ready_o;
  assign s2_load        = s1_adv && s1_valid_q && !flush_i;

  // ---- S1: operand capture ----
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_man_d   = s1_man_q;
    s1_exp_d   = s1_exp_q;
    s1_sign_d  = s1_sign_q;
    if (flush_i)
      s1_valid_d = 1'b0;
    else if (in_fire)
      s1_valid_d = 1'b1;
    else if (s1_adv)
      s1_valid_d = 1'b0;
    if (in_fire) begin
      s1_man_d  = bus.man_i;
      s1_exp_d  = bus.exp_i;
      s1_sign_d = bus.sign_i;
    end
  end

  add_lzc #(
    .WIDTH     (MAN_WIDTH),
    .MODE      (1),
    .CNT_WIDTH (6)
  ) u_lzc (
    .in_i    (s1_man_q),
    .cnt_o   (lzc_cnt),
    .empty_o (lzc_empty)
  );

  // ---- S1 -> S2: barrel shift and exponent adjust ----
  always_comb begin
    sh     = shift_amt(s1_exp_q, lzc_cnt);
    man_sh = s1_man_q << sh;
    exp_sh = s1_exp_q - EXP_WIDTH'(sh);

    s2_valid_d  = s2_valid_q;
    s2_man_d    = s2_man_q;
    s2_exp_d    = s2_exp_q;
    s2_sign_d   = s2_sign_q;
    s2_zero_d   = s2_zero_q;
    s2_denorm_d = s2_denorm_q;

    if (flush_i)
      s2_valid_d = 1'b0;
    else if (s1_adv)
      s2_valid_d = s1_valid_q;

    if (s2_load) begin
      s2_sign_d = s1_sign_q;
      if (lzc_empty) begin
        s2_man_d    = '0;
        s2_exp_d    = '0;
        s2_zero_d   = 1'b1;
        s2_denorm_d = 1'b0;
      end else if (!man_sh[MAN_WIDTH-1] || (s1_exp_q == '0)) begin
        s2_man_d    = man_sh;
        s2_exp_d    = '0;
        s2_zero_d   = 1'b0;
        s2_denorm_d = 1'b1;
      end else begin
        s2_man_d    = man_sh;
        s2_exp_d    = exp_sh;
        s2_zero_d   = 1'b0;
        s2_denorm_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_valid_q  <= 1'b0;
      s1_man_q    <= '0;
      s1_exp_q    <= '0;
      s1_sign_q   <= 1'b0;
      s2_valid_q  <= 1'b0;
      s2_man_q    <= '0;
      s2_exp_q    <= '0;
      s2_sign_q   <= 1'b0;
      s2_zero_q   <= 1'b0;
      s2_denorm_q <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_man_q    <= s1_man_d;
      s1_exp_q    <= s1_exp_d;
      s1_sign_q   <= s1_sign_d;
      s2_valid_q  <= s2_valid_d;
      s2_man_q    <= s2_man_d;
      s2_exp_q    <= s2_exp_d;
      s2_sign_q   <= s2_sign_d;
      s2_zero_q   <= s2_zero_d;
      s2_denorm_q <= s2_denorm_d;
    end
  end

  // ---- S2: registered outputs ----
  assign bus.out_valid_o = s2_valid_q;
  assign bus.man_o       = s2_man_q;
  assign bus.exp_o       = s2_exp_q;
  assign bus.sign_o      = s2_sign_q;
  assign bus.zero_o      = s2_zero_q;
  assign bus.denorm_o    = s2_denorm_q;

endmodule : add_norm
